seg7_scan_driver: RTL and testbench

//  Downstream consumer of the 16-bit display value captured from the core's R3 writes on the board top.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_font.sv | 11 +
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex font for the four-digit 7-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational nibble to active-low segment decoder.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: tear-free frame-boundary commit,
// leading-zero blanking and 16-level per-slot brightness PWM.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV  = 16'd25000,
  parameter logic [3:0]  RESET_ON_LVL = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  output logic [3:0]  anode,
  output logic [7:0]  catode,
  output logic        frame_tick,
  output logic        pending
);

  localparam logic [16:0] SLOT_Q = {1'b0, REFRESH_DIV} >> 4;

  logic [15:0] slot_cnt;
  logic [1:0]  digit_idx;
  logic [15:0] shadow_data, active_data;
  logic [3:0]  shadow_dp, active_dp;
  logic [3:0]  bright_q;

  logic        slot_tc, frame_bnd;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_seg;
  logic        cur_blank;
  logic [16:0] lit_lim;
  logic        lit;

  assign slot_tc   = (slot_cnt == REFRESH_DIV - 16'd1);
  assign frame_bnd = slot_tc && (digit_idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_tc) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + 16'd1;
    end
  end

  // A load landing on the boundary goes straight to active and never shows as pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
      bright_q    <= RESET_ON_LVL;
    end else begin
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp;
      end
      if (frame_bnd) begin
        bright_q <= brightness;
        pending  <= 1'b0;
        if (load) begin
          active_data <= data;
          active_dp   <= dp;
        end else if (pending) begin
          active_data <= shadow_data;
          active_dp   <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign cur_nib = active_data[{digit_idx, 2'b00} +: 4];

  seg7_font u_font (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_comb begin
    cur_blank = 1'b0;
    case (digit_idx)
      2'd1:    cur_blank = (active_data[15:4]  == 12'd0);
      2'd2:    cur_blank = (active_data[15:8]  == 8'd0);
      2'd3:    cur_blank = (active_data[15:12] == 4'd0);
      default: cur_blank = 1'b0;
    endcase
    cur_blank = cur_blank && blank_lz;
  end

  assign lit_lim = ({13'd0, bright_q} + 17'd1) * SLOT_Q;
  assign lit     = ({1'b0, slot_cnt} < lit_lim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode      <= ANODE_OFF;
      catode     <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_bnd;
      if (lit) begin
        anode  <= ~(4'b0001 << digit_idx);
        catode <= {~active_dp[digit_idx], cur_blank ? SEG_BLANK : cur_seg};
      end else begin
        anode  <= ANODE_OFF;
        catode <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic against a
// cycle-count based reference model of the display.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic        frame_tick;
  logic        pending;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: cycles since reset release, displayed and staged values.
  int          m_t;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  logic        m_pend;
  int          m_bright;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.REFRESH_DIV(16'd16), .RESET_ON_LVL(4'd15)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load       (load),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .anode      (anode),
    .catode     (catode),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_active = '0; m_shadow = '0; m_dp = '0; m_sdp = '0;
    m_pend = 1'b0; m_bright = 15;
  endtask

  task automatic check_reset_outputs();
    check("rst_anode",   {4'h0, anode},      8'h0F);
    check("rst_catode",  catode,             8'hFF);
    check("rst_tick",    {7'h0, frame_tick}, 8'h00);
    check("rst_pending", {7'h0, pending},    8'h00);
  endtask

  // One clock: predict pins from model state and current inputs, check, advance model.
  task automatic cyc();
    int slot, dig;
    logic bnd, blank;
    logic [3:0] e_an;
    logic [7:0] e_cat;
    logic [15:0] upper;
    slot  = m_t % 16;
    dig   = (m_t / 16) % 4;
    bnd   = ((m_t % 64) == 63);
    upper = m_active >> (4 * dig);
    blank = blank_lz && (dig != 0) && (upper == 16'd0);
    if (slot <= m_bright) begin
      e_an  = 4'hF ^ (4'b0001 << dig);
      e_cat = {~m_dp[dig], blank ? 7'h7F : font[upper[3:0]]};
    end else begin
      e_an  = 4'hF;
      e_cat = 8'hFF;
    end
    if (bnd) begin
      if (load) begin
        m_active = data; m_dp = dp;
      end else if (m_pend) begin
        m_active = m_shadow; m_dp = m_sdp;
      end
      m_pend   = 1'b0;
      m_bright = int'(brightness);
    end
    if (load) begin
      m_shadow = data; m_sdp = dp;
      if (!bnd) m_pend = 1'b1;
    end
    m_t++;
    @(posedge clk);
    #1;
    check("anode",   {4'h0, e_an},       {4'h0, anode});
    check("catode",  catode,             e_cat);
    check("tick",    {7'h0, frame_tick}, {7'h0, bnd});
    check("pending", {7'h0, pending},    {7'h0, m_pend});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data = d; dp = p; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data = '0; load = 1'b0; dp = '0; blank_lz = 1'b0; brightness = 4'd15;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs();
    end
    reset = 1'b1;

    run(70);
    do_load(16'h12AF, 4'h0);
    run(140);

    blank_lz = 1'b1;
    do_load(16'h0005, 4'h0);
    run(140);
    do_load(16'h0000, 4'h0);
    run(140);
    do_load(16'h0305, 4'b1010);
    run(140);

    brightness = 4'd3;
    run(200);
    brightness = 4'd0;
    run(140);
    brightness = 4'd15;
    run(70);

    // Load exactly on the boundary cycle.
    for (int i = 0; i < 64 && (m_t % 64) != 63; i++) cyc();
    do_load(16'hBEEF, 4'h1);
    run(140);

    // Two loads within one frame: only the later value may appear.
    for (int i = 0; i < 64 && (m_t % 64) != 5; i++) cyc();
    do_load(16'h1111, 4'h0);
    run(10);
    do_load(16'h2222, 4'h0);
    run(140);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        data = 16'($urandom);
        if ($urandom_range(0, 1) == 0) data = data >> (4 * $urandom_range(1, 3));
        dp   = 4'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
      cyc();
    end
    load = 1'b0;

    // Mid-frame asynchronous reset.
    run(23);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    brightness = 4'd7;
    run(140);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
